imem_loader: RTL

Boot-time loader directly upstream of the processor's instruction memory. Accepts a framed byte stream (from a UART receiver or the test harness) and assembles big-endian 32-bit words. Writes each word into instruction memory at consecutive 12-bit addresses from 0, and holds the processor in reset until a complete, checksum-valid image has been written.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   state_e          : loader FSM states
//   SyncByteDefault  : default frame start marker
//   LenBits          : width of the word-count field in the frame header
//   is_rx_state()    : states in which the loader accepts bytes
package imem_loader_pkg;

  localparam int unsigned StateBits       = 3;
  localparam int unsigned LenBits         = 16;
  localparam logic [7:0]  SyncByteDefault = 8'hA5;

  typedef enum logic [StateBits-1:0] {
    StIdle  = 3'd0,
    StLenHi = 3'd1,
    StLenLo = 3'd2,
    StData  = 3'd3,
    StCsum  = 3'd4,
    StDone  = 3'd5,
    StError = 3'd6
  } state_e;

  // Terminal states (done/error) stop accepting bytes until reset.
  function automatic logic is_rx_state(state_e s);
    return (s != StDone) && (s != StError);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader feeding the instruction-memory write port.
// Receives a framed byte stream (SYNC, LEN_HI, LEN_LO, N*4 data bytes, CSUM),
// assembles big-endian 32-bit words and writes them at consecutive addresses
// from 0. The processor is held in reset until a checksum-valid image is in.
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   in_data/in_valid      : received byte and its qualifier
//   in_ready              : loader accepts a byte this cycle
//   imem_wEn/addr/dataIn  : one-cycle instruction-memory write
//   cpu_reset             : processor reset, released once the load is verified
//   done / error          : load verified / length or checksum failure
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_WORDS  = 4096,
  parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_wEn,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_dataIn,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  state_e               state_q, state_d;
  logic [LenBits-1:0]   len_q, len_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [LenBits-1:0]   word_cnt_q, word_cnt_d;
  logic [23:0]          shift_q, shift_d;
  logic [7:0]           xor_q, xor_d;
  logic                 wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic                 accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      xor_q      <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      xor_q      <= xor_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Outputs decode only registered state, never in_valid/in_data.
  always_comb begin
    in_ready    = is_rx_state(state_q);
    done        = (state_q == StDone);
    error       = (state_q == StError);
    cpu_reset   = (state_q != StDone);
    imem_wEn    = wen_q;
    imem_addr   = addr_q;
    imem_dataIn = data_q;
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
        byte_cnt_d = '0;
        word_cnt_d = '0;
        xor_d      = '0;
        // Non-sync bytes are dropped so a stray prefix resynchronises.
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = in_data;
          if (32'({len_q[15:8], in_data}) > MAX_WORDS) begin
            state_d = StError;
          end else if ({len_q[15:8], in_data} == '0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          xor_d      = xor_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_data};
          if (byte_cnt_q == 2'd3) begin
            wen_d      = 1'b1;
            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
            data_d     = {shift_q, in_data};
            word_cnt_d = word_cnt_q + 1'b1;
            if ((word_cnt_q + 1'b1) == len_q) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        // Terminal until reset.
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
